caesar_encoder: RTL and testbench
=================================

CAESAR_ENCODER -- requirements
Module: caesar_encoder

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter SHALL be: SHIFT, default 3, Caesar shift added to the input digit; legal range 0..21.
REQ-003 Port ready  input  1  clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Ports a, b, c, d  input  1 each  plaintext digit bits; a is MSB, d is LSB.
REQ-006 Ports S4, S3, S2, S1, S0  output  1 each  registered cipher code; S4 is MSB.
REQ-007 Ports c0..c6  output  1 each  7-segment drive, active-high; c0=seg a, c1=b, c2=c, c3=d, c4=e, c5=f, c6=g.

Function
REQ-008 The block SHALL form the 4-bit input value D = {a,b,c,d}.
REQ-009 D in 0..9 SHALL be valid; D in 10..15 SHALL be invalid.
REQ-010 Next code for valid D SHALL be D + SHIFT, computed 5 bits wide, no wrap; the SHIFT range keeps the result at or below 30.
REQ-011 Next code for invalid D SHALL be the error code 5'b11111 (31).
REQ-012 {S4..S0} SHALL load the next code on every rising edge of ready; latency is 1 ready edge from input to S.
REQ-013 Input changes between ready edges SHALL have no effect on S until the next rising edge.
REQ-014 Outputs c0..c6 SHALL be a purely combinational decode of the registered S; they change in the same cycle S changes.
REQ-015 Decode of S 0..15 SHALL be hex digits, listed as c0..c6:
- 0 1111110, 1 0110000, 2 1101101, 3 1111001
- 4 0110011, 5 1011011, 6 1011111, 7 1110000
- 8 1111111, 9 1111011, A 1110111, b 0011111
- C 1001110, d 0111101, E 1001111, F 1000111
REQ-016 S = 31 SHALL decode to a dash, c0..c6 = 0000001.
REQ-017 S in 16..30 SHALL decode to blank, c0..c6 = 0000000.
REQ-018 The block SHALL have no handshake; every ready edge is an unconditional load.

Reset
REQ-019 While reset = 1, {S4..S0} SHALL be 5'b00000 immediately, independent of ready.
REQ-020 While reset = 1, c0..c6 SHALL therefore be 1111110, showing "0".
REQ-021 Reset asserted mid-operation SHALL clear S at once; no ready edge is needed.
REQ-022 Ready edges during reset SHALL be ignored.
REQ-023 After reset deasserts, the first rising ready edge SHALL load the code from the current D.
REQ-024 Reset deassertion coincident with a ready edge SHALL hold S at 0 for that edge.

Verification
REQ-025 A bench clock generator (test-only, not synthesized) SHALL toggle ready with a 2-time-unit period.
REQ-026 The bench SHALL cover these directed scenarios with SHIFT=3:
- reset=1, any D -> S=00000, c0..c6=1111110.
- Sweep D=0..9, one ready edge each -> S=3..12, display 3,4,5,6,7,8,9,A,b,C; D=0 gives 1111001, D=9 gives 1001110.
- D=10..15 -> S=11111, c0..c6=0000001.
- Change D between edges -> S unchanged until the next rising ready edge.
- D=9 loaded (S=01100), then a reset pulse between edges -> S=00000 immediately; the first edge after release reloads 01100.
- SHIFT=21, D=9 -> S=11110 (30), c0..c6=0000000.

Source files
------------

// File: rtl/caesar_encoder.sv
// Caesar-shift encoder for one BCD digit: the shifted code is registered on each
// rising edge of ready and shown on an active-high 7-segment display.
module caesar_encoder #(
  parameter int unsigned SHIFT = 3
) (
  input  logic ready,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic S4,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6
);

  localparam logic [4:0] ERR_CODE  = 5'b11111;
  localparam logic [4:0] SHIFT_VAL = 5'(SHIFT);

  logic [3:0] digit;
  logic [4:0] code_d;
  logic [4:0] code_q;
  logic [6:0] seg;   // seg[6] drives c0 (segment a) ... seg[0] drives c6 (segment g)

  assign digit = {a, b, c, d};

  // Digits above 9 are not plaintext; they map to the dash code
  always_comb begin
    code_d = ERR_CODE;
    if (digit <= 4'd9) begin
      code_d = {1'b0, digit} + SHIFT_VAL;
    end
  end

  always_ff @(posedge ready or posedge reset) begin
    if (reset) begin
      code_q <= 5'd0;
    end else begin
      code_q <= code_d;
    end
  end

  always_comb begin
    seg = 7'b0000000;
    case (code_q)
      5'd0:    seg = 7'b1111110;
      5'd1:    seg = 7'b0110000;
      5'd2:    seg = 7'b1101101;
      5'd3:    seg = 7'b1111001;
      5'd4:    seg = 7'b0110011;
      5'd5:    seg = 7'b1011011;
      5'd6:    seg = 7'b1011111;
      5'd7:    seg = 7'b1110000;
      5'd8:    seg = 7'b1111111;
      5'd9:    seg = 7'b1111011;
      5'd10:   seg = 7'b1110111;
      5'd11:   seg = 7'b0011111;
      5'd12:   seg = 7'b1001110;
      5'd13:   seg = 7'b0111101;
      5'd14:   seg = 7'b1001111;
      5'd15:   seg = 7'b1000111;
      5'd31:   seg = 7'b0000001;
      default: seg = 7'b0000000;
    endcase
  end

  assign {S4, S3, S2, S1, S0} = code_q;
  assign {c0, c1, c2, c3, c4, c5, c6} = seg;

endmodule

// File: tb/tb_caesar_encoder.sv
// Directed bench for caesar_encoder: two instances (SHIFT=3 and SHIFT=21) checked
// every cycle against an arithmetic model, plus hand-computed literal expectations.
`timescale 1ns/100ps
module tb_caesar_encoder;

  logic ready = 1'b0;
  logic reset = 1'b1;
  logic [3:0] din = 4'd0;

  wire [4:0] s3_w, s21_w;
  wire [6:0] seg3_w, seg21_w;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp3 = 5'd0;
  logic [4:0] exp21 = 5'd0;

  always #1 ready = ~ready;

  caesar_encoder #(.SHIFT(3)) u_dut3 (
    .ready(ready), .reset(reset),
    .a(din[3]), .b(din[2]), .c(din[1]), .d(din[0]),
    .S4(s3_w[4]), .S3(s3_w[3]), .S2(s3_w[2]), .S1(s3_w[1]), .S0(s3_w[0]),
    .c0(seg3_w[6]), .c1(seg3_w[5]), .c2(seg3_w[4]), .c3(seg3_w[3]),
    .c4(seg3_w[2]), .c5(seg3_w[1]), .c6(seg3_w[0])
  );

  caesar_encoder #(.SHIFT(21)) u_dut21 (
    .ready(ready), .reset(reset),
    .a(din[3]), .b(din[2]), .c(din[1]), .d(din[0]),
    .S4(s21_w[4]), .S3(s21_w[3]), .S2(s21_w[2]), .S1(s21_w[1]), .S0(s21_w[0]),
    .c0(seg21_w[6]), .c1(seg21_w[5]), .c2(seg21_w[4]), .c3(seg21_w[3]),
    .c4(seg21_w[2]), .c5(seg21_w[1]), .c6(seg21_w[0])
  );

  // Plain arithmetic: digit plus shift, 31 for non-digits
  function automatic logic [4:0] model_code(input int dig, input int shift);
    if (dig > 9) return 5'd31;
    return 5'(dig + shift);
  endfunction

  // Display rule: hex glyph for 0..15, dash for 31, blank otherwise
  function automatic logic [6:0] model_seg(input logic [4:0] code);
    logic [6:0] hex_tbl [16];
    hex_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (code < 5'd16) return hex_tbl[code[3:0]];
    if (code == 5'd31) return 7'b0000001;
    return 7'b0000000;
  endfunction

  always @(posedge ready or posedge reset) begin
    if (reset) begin
      exp3 = 5'd0;
      exp21 = 5'd0;
    end else begin
      exp3 = model_code(int'(din), 3);
      exp21 = model_code(int'(din), 21);
    end
  end

  always @(negedge ready) begin
    checks++;
    if (s3_w !== exp3 || seg3_w !== model_seg(exp3)) begin
      errors++;
      $display("FAIL model_shift3 t=%0t D=%0d S=%b seg=%b required S=%b seg=%b",
               $time, din, s3_w, seg3_w, exp3, model_seg(exp3));
    end
    checks++;
    if (s21_w !== exp21 || seg21_w !== model_seg(exp21)) begin
      errors++;
      $display("FAIL model_shift21 t=%0t D=%0d S=%b seg=%b required S=%b seg=%b",
               $time, din, s21_w, seg21_w, exp21, model_seg(exp21));
    end
  end

  task automatic lit(input string name, input logic [4:0] s_act, input logic [6:0] g_act,
                     input logic [4:0] s_req, input logic [6:0] g_req);
    checks++;
    if (s_act !== s_req || g_act !== g_req) begin
      errors++;
      $display("FAIL %s S=%b seg=%b required S=%b seg=%b", name, s_act, g_act, s_req, g_req);
    end else begin
      $display("ok   %s S=%b seg=%b", name, s_act, g_act);
    end
  endtask

  // Called at posedge+0.5: drive D, advance one edge, return at posedge+0.5
  task automatic step(input logic [3:0] dig);
    din = dig;
    @(posedge ready);
    #0.5;
  endtask

  initial begin
    #0.3;
    lit("reset_initial", s3_w, seg3_w, 5'b00000, 7'b1111110);
    din = 4'd5;
    repeat (3) @(posedge ready);
    #0.5;
    lit("reset_ignores_edges", s3_w, seg3_w, 5'b00000, 7'b1111110);
    reset = 1'b0;

    step(4'd0);
    lit("sweep_d0", s3_w, seg3_w, 5'd3, 7'b1111001);
    for (int i = 1; i < 9; i++) step(4'(i));
    lit("sweep_d8", s3_w, seg3_w, 5'd11, 7'b0011111);
    step(4'd9);
    lit("sweep_d9", s3_w, seg3_w, 5'd12, 7'b1001110);

    for (int i = 10; i < 16; i++) begin
      step(4'(i));
      lit($sformatf("invalid_d%0d", i), s3_w, seg3_w, 5'b11111, 7'b0000001);
    end

    step(4'd2);
    lit("hold_before", s3_w, seg3_w, 5'd5, 7'b1011011);
    din = 4'd7;
    #0.4;
    lit("hold_between_edges", s3_w, seg3_w, 5'd5, 7'b1011011);
    @(posedge ready);
    #0.5;
    lit("hold_after_edge", s3_w, seg3_w, 5'd10, 7'b1110111);

    step(4'd9);
    lit("pre_reset_d9", s3_w, seg3_w, 5'b01100, 7'b1001110);
    lit("shift21_d9", s21_w, seg21_w, 5'b11110, 7'b0000000);
    #0.1 reset = 1'b1;
    #0.1;
    lit("async_reset_clear", s3_w, seg3_w, 5'b00000, 7'b1111110);
    #0.1 reset = 1'b0;
    @(posedge ready);
    #0.5;
    lit("reload_after_reset", s3_w, seg3_w, 5'b01100, 7'b1001110);

    step(4'd0);
    lit("shift21_d0", s21_w, seg21_w, 5'd21, 7'b0000000);
    step(4'd12);
    lit("shift21_invalid", s21_w, seg21_w, 5'b11111, 7'b0000001);

    @(posedge ready);
    #0.5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
